// File: rtl/cook_controller.sv
// cook_controller: owns one microwave cook cycle. Handles the BCD MM:SS countdown, the magnetron duty cycle,
// pause/door/cancel events and the end-of-cook beep. Optional quick-add key: define ADD_30S_EN.
module cook_controller #(
    parameter int unsigned TICKS_PER_SEC = 32'd50_000_000,
    parameter int unsigned BEEP_SECS     = 32'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    input  logic       door_open,
`ifdef ADD_30S_EN
    input  logic       add30,
`endif
    input  logic [3:0] first_s,
    input  logic [3:0] second_s,
    input  logic [3:0] first_m,
    input  logic [3:0] second_m,
    input  logic [7:0] power_in,
    input  logic [7:0] temperature_in,
    output logic [3:0] rem_first_s,
    output logic [3:0] rem_second_s,
    output logic [3:0] rem_first_m,
    output logic [3:0] rem_second_m,
    output logic [7:0] temperature_target,
    output logic       magnetron_on,
    output logic       lamp_on,
    output logic       turntable_on,
    output logic       beep,
    output logic [1:0] state,
    output logic       done,
    output logic       load_err
);

    localparam int unsigned PW = (TICKS_PER_SEC > 32'd1) ? $clog2(TICKS_PER_SEC) : 32'd1;
    localparam int unsigned BW = (BEEP_SECS > 32'd1) ? $clog2(BEEP_SECS) : 32'd1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 32'd1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_SECS - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_COOK   = 2'b01,
        ST_PAUSED = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    function automatic logic bcd_valid(input logic [15:0] t);
        return (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) && (t[11:8] <= 4'd9) && (t[15:12] <= 4'd9);
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] s1, s10, m1, m10;
        {m10, m1, s10, s1} = t;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    // Adds 30 s with BCD carry; anything past 99:59 pins to 99:59.
    function automatic logic [15:0] bcd_add30(input logic [15:0] t);
        logic [3:0]  s10, m1, m10;
        logic [15:0] r;
        s10 = t[7:4] + 4'd3;
        m1  = t[11:8];
        m10 = t[15:12];
        if (s10 > 4'd5) begin
            s10 = s10 - 4'd6;
            m1  = m1 + 4'd1;
        end else begin
            m1  = t[11:8];
        end
        if (m1 > 4'd9) begin
            m1  = 4'd0;
            m10 = m10 + 4'd1;
        end else begin
            m10 = t[15:12];
        end
        if (m10 > 4'd9) begin
            r = 16'h9959;
        end else begin
            r = {m10, m1, s10, t[3:0]};
        end
        return r;
    endfunction

    function automatic logic [3:0] on_secs(input logic [7:0] p);
        logic [7:0] q;
        q = p / 8'd10;
        if ((p != 8'd0) && (q == 8'd0)) begin
            q = 8'd1;
        end else begin
            q = p / 8'd10;
        end
        return q[3:0];
    endfunction

    state_e        state_r, state_s;
    logic [15:0]   time_r, time_s;
    logic [7:0]    power_r, power_s;
    logic [7:0]    temp_r, temp_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [3:0]    window_r, window_s;
    logic [BW-1:0] beep_cnt_r, beep_cnt_s;
    logic          mag_r, lamp_r, turn_r, beep_r, done_r, load_err_r;
    logic          mag_s, lamp_s, turn_s, beep_s, done_s, load_err_s;
    logic          tick_s, preset_ok_s, add30_go_s;
    logic [15:0]   preset_s;
    logic [7:0]    power_clamp_s;

    assign preset_s      = {second_m, first_m, second_s, first_s};
    assign preset_ok_s   = bcd_valid(preset_s) && (preset_s != 16'h0000);
    assign power_clamp_s = (power_in > 8'd100) ? 8'd100 : power_in;
    assign tick_s        = (presc_r == PRESC_LAST);
`ifdef ADD_30S_EN
    assign add30_go_s    = add30 && !cancel && !door_open && !pause && !start;
`else
    assign add30_go_s    = 1'b0;
`endif

    // Next-state, countdown, prescaler/window and registered-output decode.
    always_comb begin
        state_s    = state_r;
        time_s     = time_r;
        power_s    = power_r;
        temp_s     = temp_r;
        presc_s    = presc_r;
        window_s   = window_r;
        beep_cnt_s = beep_cnt_r;
        load_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cancel || door_open || pause) begin
                    state_s = ST_IDLE;
                end else if (start) begin
                    if (preset_ok_s) begin
                        state_s  = ST_COOK;
                        time_s   = preset_s;
                        power_s  = power_clamp_s;
                        temp_s   = temperature_in;
                        presc_s  = '0;
                        window_s = 4'd0;
                    end else begin
                        load_err_s = 1'b1;
                    end
                end else if (add30_go_s) begin
                    state_s  = ST_COOK;
                    time_s   = 16'h0030;
                    power_s  = 8'd100;
                    temp_s   = 8'd100;
                    presc_s  = '0;
                    window_s = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COOK: begin
                if (cancel) begin
                    state_s = ST_IDLE;
                end else if (door_open || pause) begin
                    state_s = ST_PAUSED;
                end else if (tick_s) begin
                    presc_s  = '0;
                    window_s = (window_r == 4'd9) ? 4'd0 : window_r + 4'd1;
                    time_s   = bcd_dec(time_r);
                    if (time_s == 16'h0000) begin
                        state_s    = ST_DONE;
                        beep_cnt_s = '0;
                    end else begin
                        time_s = add30_go_s ? bcd_add30(time_s) : time_s;
                    end
                end else begin
                    presc_s = presc_r + PW'(1);
                    time_s  = add30_go_s ? bcd_add30(time_r) : time_r;
                end
            end
            ST_PAUSED: begin
                if (cancel) begin
                    state_s = ST_IDLE;
                end else if (door_open || pause) begin
                    state_s = ST_PAUSED;
                end else if (start) begin
                    state_s = ST_COOK;
                end else begin
                    time_s = add30_go_s ? bcd_add30(time_r) : time_r;
                end
            end
            ST_DONE: begin
                if (cancel || door_open || start) begin
                    state_s = ST_IDLE;
                end else if (add30_go_s) begin
                    state_s  = ST_COOK;
                    time_s   = 16'h0030;
                    power_s  = 8'd100;
                    temp_s   = 8'd100;
                    presc_s  = '0;
                    window_s = 4'd0;
                end else if (tick_s) begin
                    presc_s = '0;
                    if (beep_cnt_r == BEEP_LAST) begin
                        state_s = ST_IDLE;
                    end else begin
                        beep_cnt_s = beep_cnt_r + BW'(1);
                    end
                end else begin
                    presc_s = presc_r + PW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Landing in IDLE (from anywhere) wipes the cook context.
        time_s     = (state_s == ST_IDLE) ? 16'h0000 : time_s;
        power_s    = (state_s == ST_IDLE) ? 8'd0 : power_s;
        temp_s     = (state_s == ST_IDLE) ? 8'd0 : temp_s;
        presc_s    = (state_s == ST_IDLE) ? '0 : presc_s;
        window_s   = (state_s == ST_IDLE) ? 4'd0 : window_s;
        beep_cnt_s = (state_s == ST_IDLE) ? '0 : beep_cnt_s;

        mag_s  = (state_s == ST_COOK) && (window_s < on_secs(power_s));
        lamp_s = (state_s == ST_COOK) || (state_s == ST_PAUSED) || door_open;
        turn_s = (state_s == ST_COOK);
        beep_s = (state_s == ST_DONE);
        done_s = (state_r == ST_COOK) && (state_s == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            time_r     <= 16'h0000;
            power_r    <= 8'd0;
            temp_r     <= 8'd0;
            presc_r    <= '0;
            window_r   <= 4'd0;
            beep_cnt_r <= '0;
            mag_r      <= 1'b0;
            lamp_r     <= 1'b0;
            turn_r     <= 1'b0;
            beep_r     <= 1'b0;
            done_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            time_r     <= time_s;
            power_r    <= power_s;
            temp_r     <= temp_s;
            presc_r    <= presc_s;
            window_r   <= window_s;
            beep_cnt_r <= beep_cnt_s;
            mag_r      <= mag_s;
            lamp_r     <= lamp_s;
            turn_r     <= turn_s;
            beep_r     <= beep_s;
            done_r     <= done_s;
            load_err_r <= load_err_s;
        end
    end

    assign rem_first_s        = time_r[3:0];
    assign rem_second_s       = time_r[7:4];
    assign rem_first_m        = time_r[11:8];
    assign rem_second_m       = time_r[15:12];
    assign temperature_target = temp_r;
    assign magnetron_on       = mag_r;
    assign lamp_on            = lamp_r;
    assign turntable_on       = turn_r;
    assign beep               = beep_r;
    assign state              = state_r;
    assign done               = done_r;
    assign load_err           = load_err_r;

endmodule

// File: tb/tb_cook_controller.sv
// Self-checking bench for cook_controller with TICKS_PER_SEC=4, BEEP_SECS=3.
module tb_cook_controller;

    localparam int T = 4;
    localparam int B = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, pause = 1'b0, cancel = 1'b0, door_open = 1'b0;
`ifdef ADD_30S_EN
    logic       add30 = 1'b0;
`endif
    logic [3:0] first_s = 4'd0, second_s = 4'd0, first_m = 4'd0, second_m = 4'd0;
    logic [7:0] power_in = 8'd0, temperature_in = 8'd0;
    logic [3:0] rem_first_s, rem_second_s, rem_first_m, rem_second_m;
    logic [7:0] temperature_target;
    logic       magnetron_on, lamp_on, turntable_on, beep, done, load_err;
    logic [1:0] state;

    always #5 clk = ~clk;

    cook_controller #(.TICKS_PER_SEC(T), .BEEP_SECS(B)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .cancel(cancel), .door_open(door_open),
`ifdef ADD_30S_EN
        .add30(add30),
`endif
        .first_s(first_s), .second_s(second_s), .first_m(first_m), .second_m(second_m),
        .power_in(power_in), .temperature_in(temperature_in),
        .rem_first_s(rem_first_s), .rem_second_s(rem_second_s), .rem_first_m(rem_first_m),
        .rem_second_m(rem_second_m), .temperature_target(temperature_target),
        .magnetron_on(magnetron_on), .lamp_on(lamp_on), .turntable_on(turntable_on), .beep(beep),
        .state(state), .done(done), .load_err(load_err)
    );

    typedef struct {
        logic        st, pa, ca, dr;
        logic [15:0] pre;
        logic [7:0]  pw, tp;
        logic [1:0]  e_st;
        logic [15:0] e_rem;
        logic [7:0]  e_tp;
        logic        e_le, e_lamp, e_mag;
    } vec_t;

    vec_t vecs [22];
    vec_t sb [$];
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_preset(input logic [15:0] t, input logic [7:0] p, input logic [7:0] tp);
        {second_m, first_m, second_s, first_s} = t;
        power_in       = p;
        temperature_in = tp;
    endtask

    function automatic logic [15:0] rem_now();
        return {rem_second_m, rem_first_m, rem_second_s, rem_first_s};
    endfunction

    function automatic logic [15:0] bcd_of(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            st    pa    ca    dr    preset    pw     tp       state  rem       temp    le    lamp  mag
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0,  8'd0,   2'd0, 16'h0000, 8'd0,   1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd50, 8'd90,  2'd0, 16'h0000, 8'd0,   1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd50, 8'd90,  2'd0, 16'h0000, 8'd0,   1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0060, 8'd50, 8'd90,  2'd0, 16'h0000, 8'd0,   1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0A00, 8'd50, 8'd90,  2'd0, 16'h0000, 8'd0,   1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 8'd50, 8'd90,  2'd0, 16'h0000, 8'd0,   1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 8'd50, 8'd90,  2'd1, 16'h0010, 8'd90,  1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 8'd50, 8'd90,  2'd1, 16'h0010, 8'd90,  1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 8'd50, 8'd90,  2'd1, 16'h0010, 8'd90,  1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 8'd50, 8'd90,  2'd1, 16'h0010, 8'd90,  1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 8'd50, 8'd90,  2'd1, 16'h0009, 8'd90,  1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 8'd50, 8'd90,  2'd0, 16'h0000, 8'd0,   1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 8'd0,  8'd150, 2'd1, 16'h1000, 8'd150, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 8'd0,  8'd150, 2'd1, 16'h1000, 8'd150, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 8'd0,  8'd150, 2'd1, 16'h1000, 8'd150, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 8'd0,  8'd150, 2'd1, 16'h1000, 8'd150, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 8'd0,  8'd150, 2'd1, 16'h0959, 8'd150, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 8'd0,  8'd150, 2'd2, 16'h0959, 8'd150, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h1000, 8'd0,  8'd150, 2'd2, 16'h0959, 8'd150, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 8'd0,  8'd150, 2'd1, 16'h0959, 8'd150, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h1000, 8'd0,  8'd150, 2'd2, 16'h0959, 8'd150, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 8'd0,  8'd150, 2'd0, 16'h0000, 8'd0,   1'b0, 1'b0, 1'b0};

        // Reset state while reset is held low.
        #12;
        chk("rst_state", state, 2'd0);
        chk("rst_rem", rem_now(), 16'h0000);
        chk("rst_temp", temperature_target, 8'd0);
        chk("rst_outs", {magnetron_on, lamp_on, turntable_on, beep, done, load_err}, 6'd0);
        reset = 1'b1;
        @(negedge clk);

        // Table vectors through the scoreboard queue.
        for (int i = 0; i < 22; i++) begin
            start = vecs[i].st; pause = vecs[i].pa; cancel = vecs[i].ca; door_open = vecs[i].dr;
            set_preset(vecs[i].pre, vecs[i].pw, vecs[i].tp);
            sb.push_back(vecs[i]);
            step();
            begin
                vec_t e;
                e = sb.pop_front();
                chk($sformatf("v%0d_state", i), state, e.e_st);
                chk($sformatf("v%0d_rem", i), rem_now(), e.e_rem);
                chk($sformatf("v%0d_temp", i), temperature_target, e.e_tp);
                chk($sformatf("v%0d_load_err", i), load_err, e.e_le);
                chk($sformatf("v%0d_lamp", i), lamp_on, e.e_lamp);
                chk($sformatf("v%0d_mag", i), magnetron_on, e.e_mag);
            end
        end
        start = 1'b0; pause = 1'b0; cancel = 1'b0; door_open = 1'b0;

        // Full 01:30 cook at 70 % power, then beep and return to IDLE.
        set_preset(16'h0130, 8'd70, 8'd200);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("cook_enter", state, 2'd1);
        chk("cook_temp", temperature_target, 8'd200);
        for (int k = 0; k < 90; k++) begin
            for (int c = 0; c < T; c++) begin
                if (c == 0) chk($sformatf("cook_rem_%0d", 90 - k), rem_now(), bcd_of(90 - k));
                chk("cook_mag", magnetron_on, 1'((k % 10) < 7));
                done_cnt += int'(done);
                step();
            end
        end
        chk("done_state", state, 2'd3);
        chk("done_rem", rem_now(), 16'h0000);
        chk("done_pulse", done, 1'b1);
        chk("done_mag", magnetron_on, 1'b0);
        chk("done_turn", turntable_on, 1'b0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("beep_%0d", i), beep, 1'b1);
            done_cnt += int'(done);
            step();
        end
        chk("beep_end_state", state, 2'd0);
        chk("beep_end", beep, 1'b0);
        chk("done_once", done_cnt, 32'd1);

        // Door open mid-cook, start ignored while open, resume keeps the prescaler phase.
        set_preset(16'h0010, 8'd100, 8'd50);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        chk("door_pre_rem", rem_now(), 16'h0007);
        repeat (2) step();
        door_open = 1'b1;
        step();
        chk("door_state", state, 2'd2);
        chk("door_mag", magnetron_on, 1'b0);
        chk("door_lamp", lamp_on, 1'b1);
        chk("door_rem", rem_now(), 16'h0007);
        start = 1'b1;
        step();
        chk("door_start_ign", state, 2'd2);
        door_open = 1'b0;
        step();
        start = 1'b0;
        chk("resume_state", state, 2'd1);
        chk("resume_mag", magnetron_on, 1'b1);
        step();
        chk("resume_hold", rem_now(), 16'h0007);
        step();
        chk("resume_tick", rem_now(), 16'h0006);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_state", state, 2'd0);

        // Asynchronous reset mid-cook, then no resume.
        set_preset(16'h0130, 8'd100, 8'd80);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("pre_rst_turn", turntable_on, 1'b1);
        reset = 1'b0;
        #1;
        chk("arst_state", state, 2'd0);
        chk("arst_rem", rem_now(), 16'h0000);
        chk("arst_temp", temperature_target, 8'd0);
        chk("arst_outs", {magnetron_on, lamp_on, turntable_on, beep, done, load_err}, 6'd0);
        step();
        reset = 1'b1;
        step();
        chk("post_rst_state", state, 2'd0);

`ifdef ADD_30S_EN
        // Quick-add: start from IDLE, carry, and saturation.
        set_preset(16'h0000, 8'd0, 8'd0);
        add30 = 1'b1;
        step();
        add30 = 1'b0;
        chk("a30_state", state, 2'd1);
        chk("a30_rem", rem_now(), 16'h0030);
        chk("a30_temp", temperature_target, 8'd100);
        chk("a30_mag", magnetron_on, 1'b1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        set_preset(16'h0045, 8'd50, 8'd10);
        start = 1'b1;
        step();
        start = 1'b0;
        add30 = 1'b1;
        step();
        add30 = 1'b0;
        chk("a30_carry", rem_now(), 16'h0115);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        set_preset(16'h9945, 8'd50, 8'd10);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("a30_pre", rem_now(), 16'h9945);
        add30 = 1'b1;
        step();
        add30 = 1'b0;
        chk("a30_sat", rem_now(), 16'h9959);
        chk("a30_sat_state", state, 2'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
